bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Two-master bus arbiter and address decoder placed in front of the shared slave bus inside top: RAM, factorial unit and multiplier.
- Master 0 is the external test/host port. Master 1 is the factorial engine's internal multiplier-access port.
- Grants bus ownership round-robin with a burst limit, muxes the granted master's command onto the slave bus, decodes the address into slave selects, and returns read data.

Parameters:
- MAX_BURST, 8, maximum consecutive granted cycles for one master while the other is requesting (range 2..255).
- ADDR_W, 8, address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- M0_req  in  1  master 0 bus request.
- M0_wr  in  1  master 0 write (1) / read (0).
- M0_address  in  ADDR_W  master 0 address.
- M0_dout  in  DATA_W  master 0 write data.
- M0_grant  out  1  master 0 owns the bus (registered).
- M1_req  in  1  master 1 bus request.
- M1_wr  in  1  master 1 write/read.
- M1_address  in  ADDR_W  master 1 address.
- M1_dout  in  DATA_W  master 1 write data.
- M1_grant  out  1  master 1 owns the bus (registered).
- S_wr  out  1  slave write strobe.
- S_address  out  ADDR_W  slave address.
- S_dout  out  DATA_W  slave write data.
- S_sel  out  3  one-hot select: bit0 RAM, bit1 factorial, bit2 multiplier.
- S0_din  in  DATA_W  RAM read data.
- S1_din  in  DATA_W  factorial read data.
- S2_din  in  DATA_W  multiplier read data.
- M_din  out  DATA_W  read data returned to the granted master.
- bus_err  out  1  one-cycle pulse on an access to an unmapped address.

Behaviour:
- Reset (asynchronous, active-low):
  - State IDLE; M0_grant=0, M1_grant=0; burst counter=0; last_owner=M1, so M0 wins the first tie; bus_err=0.
  - All combinational outputs resolve to 0.
- FSM states: IDLE, GNT0, GNT1. Grants are decoded from the registered state.
- IDLE:
  - Only M0_req → GNT0. Only M1_req → GNT1.
  - Both → the master that is not last_owner.
  - Neither → stay in IDLE.
- GNTx:
  - req_x dropped → GNTy if req_y, else IDLE.
  - req_x held, req_y asserted, counter==MAX_BURST-1 → GNTy (forced release).
  - req_x held otherwise → stay in GNTx. The counter increments only while req_y is asserted and saturates; it clears whenever req_y=0.
  - On every transition into GNTx: counter=0, last_owner=x.
- Latency: a request sampled at edge k produces a grant visible after edge k. A switchover between masters takes one edge with no idle cycle.
- Command mux (combinational from state):
  - The granted master drives S_wr/S_address/S_dout.
  - In IDLE all three are 0.
  - S_wr is never asserted without a grant.
- Decode on S_address[7:5]:
  - 000 → S_sel=001 (RAM, 0x00–0x1F).
  - 001 → 010 (factorial, 0x20–0x3F).
  - 010 → 100 (multiplier, 0x40–0x5F).
  - Any other value, or IDLE → S_sel=000.
- Read data: M_din = din of the selected slave, 0 if none selected. Same cycle, combinational. Each master qualifies M_din with its own grant.
- bus_err:
  - Registered. Set for exactly one cycle following any granted cycle with S_sel=000.
  - Applies to both reads and writes.
  - A write to an unmapped address is dropped (S_sel=000 means no slave sees it).
- Simultaneous events:
  - Request drop and forced release on the same edge → the drop rule wins; the result is identical either way.
  - Both requests dropped → IDLE.
- Reset mid-grant: grants drop immediately (asynchronous) and S_wr goes to 0 in the same instant. The first grant after reset goes to M0 on a tie.

Decomposition:
- Package bus_pkg holds:
  - State encoding constants (IDLE/GNT0/GNT1).
  - Address region base constants: RAM 3'b000, FACT 3'b001, MUL 3'b010.
  - S_sel one-hot constants.
- Sub-module bus_addr_decode: purely combinational, S_address → S_sel and the read-data mux. The top-level arbiter keeps the FSM, burst counter, last_owner and bus_err.

Test Plan:
1. Hold reset_n=0 with random inputs → grants=0, S_wr=0, S_sel=000, M_din=0, bus_err=0. Release, M0_req=1 only → M0_grant=1 after the next rising edge; M0 write to 0x05 data 0x05 → S_sel=001, S_wr=1.
2. M0_req and M1_req both rise on the same edge after reset → M0 granted first. M0 drops after 2 cycles → M1_grant on the next edge, no idle gap.
3. MAX_BURST=8, both hold requests continuously → grant alternates exactly every 8 cycles. Then M1 drops → M0 keeps the grant indefinitely with no forced release.
4. M1 granted: write 0x40=20, 0x42=20 → S_sel=100 with data forwarded. Read 0x44 while S2_din=400 → M_din=400.
5. M0 granted: read 0x80, then write 0xE0 → S_sel=000, M_din=0, no slave strobe, bus_err pulses 1 cycle after each access.
6. Assert reset_n=0 mid-way through a 5-cycle M1 burst → M1_grant falls asynchronously. Release with both requesting → M0 granted first.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared encodings for the two-master bus arbiter and its address decoder.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } bus_state_e;

  localparam logic [2:0] REGION_RAM  = 3'b000;
  localparam logic [2:0] REGION_FACT = 3'b001;
  localparam logic [2:0] REGION_MUL  = 3'b010;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_RAM  = 3'b001;
  localparam logic [2:0] SEL_FACT = 3'b010;
  localparam logic [2:0] SEL_MUL  = 3'b100;

endpackage

// File: rtl/bus_addr_decode.sv
// Region decode of the slave address into one-hot selects plus the read-data return mux.
module bus_addr_decode #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_valid,
  input  logic [2:0]        i_region,
  input  logic [DATA_W-1:0] i_s0_din,
  input  logic [DATA_W-1:0] i_s1_din,
  input  logic [DATA_W-1:0] i_s2_din,
  output logic [2:0]        o_sel,
  output logic [DATA_W-1:0] o_din
);
  import bus_pkg::*;

  always_comb begin
    o_sel = SEL_NONE;
    o_din = '0;
    if (i_valid) begin
      case (i_region)
        REGION_RAM:  o_sel = SEL_RAM;
        REGION_FACT: o_sel = SEL_FACT;
        REGION_MUL:  o_sel = SEL_MUL;
        default:     o_sel = SEL_NONE;
      endcase
    end
    case (o_sel)
      SEL_RAM:  o_din = i_s0_din;
      SEL_FACT: o_din = i_s1_din;
      SEL_MUL:  o_din = i_s2_din;
      default:  o_din = '0;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter with burst limit, command mux, address decode and bus error flag.
module bus_arbiter #(
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              M0_req,
  input  logic              M0_wr,
  input  logic [ADDR_W-1:0] M0_address,
  input  logic [DATA_W-1:0] M0_dout,
  output logic              M0_grant,
  input  logic              M1_req,
  input  logic              M1_wr,
  input  logic [ADDR_W-1:0] M1_address,
  input  logic [DATA_W-1:0] M1_dout,
  output logic              M1_grant,
  output logic              S_wr,
  output logic [ADDR_W-1:0] S_address,
  output logic [DATA_W-1:0] S_dout,
  output logic [2:0]        S_sel,
  input  logic [DATA_W-1:0] S0_din,
  input  logic [DATA_W-1:0] S1_din,
  input  logic [DATA_W-1:0] S2_din,
  output logic [DATA_W-1:0] M_din,
  output logic              bus_err
);
  import bus_pkg::*;

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  bus_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_last_owner, w_last_owner_nxt;  // 0 = M0, 1 = M1
  logic             r_bus_err;
  logic             w_granted;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_last_owner <= 1'b1;
      r_bus_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_bus_err    <= w_granted && (S_sel == SEL_NONE);
    end
  end

  // Counter only advances while the other master is waiting; reaching CNT_LAST forces a handover.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_last_owner_nxt = r_last_owner;
    case (r_state)
      ST_IDLE: begin
        if (M0_req && M1_req) w_state_nxt = r_last_owner ? ST_GNT0 : ST_GNT1;
        else if (M0_req)      w_state_nxt = ST_GNT0;
        else if (M1_req)      w_state_nxt = ST_GNT1;
      end
      ST_GNT0: begin
        if (!M0_req)                     w_state_nxt = M1_req ? ST_GNT1 : ST_IDLE;
        else if (!M1_req)                w_cnt_nxt   = '0;
        else if (r_cnt == CNT_LAST)      w_state_nxt = ST_GNT1;
        else                             w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      ST_GNT1: begin
        if (!M1_req)                     w_state_nxt = M0_req ? ST_GNT0 : ST_IDLE;
        else if (!M0_req)                w_cnt_nxt   = '0;
        else if (r_cnt == CNT_LAST)      w_state_nxt = ST_GNT0;
        else                             w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if ((w_state_nxt != r_state) && (w_state_nxt != ST_IDLE)) begin
      w_cnt_nxt        = '0;
      w_last_owner_nxt = (w_state_nxt == ST_GNT1);
    end
  end

  assign M0_grant  = (r_state == ST_GNT0);
  assign M1_grant  = (r_state == ST_GNT1);
  assign w_granted = M0_grant || M1_grant;
  assign bus_err   = r_bus_err;

  always_comb begin
    S_wr      = 1'b0;
    S_address = '0;
    S_dout    = '0;
    case (r_state)
      ST_GNT0: begin
        S_wr      = M0_wr;
        S_address = M0_address;
        S_dout    = M0_dout;
      end
      ST_GNT1: begin
        S_wr      = M1_wr;
        S_address = M1_address;
        S_dout    = M1_dout;
      end
      default: ;
    endcase
  end

  bus_addr_decode #(
    .DATA_W (DATA_W)
  ) u_decode (
    .i_valid  (w_granted),
    .i_region (S_address[ADDR_W-1 -: 3]),
    .i_s0_din (S0_din),
    .i_s1_din (S1_din),
    .i_s2_din (S2_din),
    .o_sel    (S_sel),
    .o_din    (M_din)
  );

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized bench for bus_arbiter against an ownership-based reference model.
module tb_bus_arbiter;
  localparam int unsigned MAX_BURST = 8;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned DATA_W    = 32;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              M0_req = 0, M0_wr = 0, M1_req = 0, M1_wr = 0;
  logic [ADDR_W-1:0] M0_address = '0, M1_address = '0;
  logic [DATA_W-1:0] M0_dout = '0, M1_dout = '0;
  logic [DATA_W-1:0] S0_din = '0, S1_din = '0, S2_din = '0;
  logic              M0_grant, M1_grant, S_wr, bus_err;
  logic [ADDR_W-1:0] S_address;
  logic [DATA_W-1:0] S_dout, M_din;
  logic [2:0]        S_sel;

  bus_arbiter #(.MAX_BURST(MAX_BURST), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .M0_req(M0_req), .M0_wr(M0_wr), .M0_address(M0_address), .M0_dout(M0_dout), .M0_grant(M0_grant),
    .M1_req(M1_req), .M1_wr(M1_wr), .M1_address(M1_address), .M1_dout(M1_dout), .M1_grant(M1_grant),
    .S_wr(S_wr), .S_address(S_address), .S_dout(S_dout), .S_sel(S_sel),
    .S0_din(S0_din), .S1_din(S1_din), .S2_din(S2_din), .M_din(M_din), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: current owner (-1 none), previous owner, cycles the other master has waited.
  int   m_own  = -1;
  int   m_last = 1;
  int   m_wait = 0;
  logic m_err  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int region_of(input logic [ADDR_W-1:0] a);
    return int'(a) / 32;
  endfunction

  task automatic model_reset();
    m_own = -1; m_last = 1; m_wait = 0; m_err = 1'b0;
  endtask

  task automatic model_step();
    int  nxt;
    bit  rx, ry;
    logic [ADDR_W-1:0] a;
    rx = 0; ry = 0;
    if (m_own < 0) begin
      if (M0_req && M1_req) nxt = 1 - m_last;
      else if (M0_req)      nxt = 0;
      else if (M1_req)      nxt = 1;
      else                  nxt = -1;
    end else begin
      rx = (m_own == 0) ? M0_req : M1_req;
      ry = (m_own == 0) ? M1_req : M0_req;
      if (!rx)                                     nxt = ry ? 1 - m_own : -1;
      else if (ry && m_wait >= int'(MAX_BURST) - 1) nxt = 1 - m_own;
      else                                         nxt = m_own;
    end
    a = (m_own == 0) ? M0_address : M1_address;
    m_err = (m_own >= 0) && (region_of(a) >= 3);
    if (nxt != m_own) begin
      m_wait = 0;
      if (nxt >= 0) m_last = nxt;
    end else if (nxt >= 0) begin
      m_wait = ry ? m_wait + 1 : 0;
    end
    m_own = nxt;
  endtask

  task automatic check_outputs();
    logic [ADDR_W-1:0] a;
    logic              wr;
    logic [DATA_W-1:0] d, din;
    logic [2:0]        sel;
    int                rg;
    a = '0; wr = 1'b0; d = '0; din = '0; sel = 3'b000;
    if (m_own == 0) begin a = M0_address; wr = M0_wr; d = M0_dout; end
    if (m_own == 1) begin a = M1_address; wr = M1_wr; d = M1_dout; end
    rg = region_of(a);
    if (m_own >= 0 && rg < 3) begin
      sel = 3'(1 << rg);
      din = (rg == 0) ? S0_din : (rg == 1) ? S1_din : S2_din;
    end
    check_eq("m0_grant",  32'(M0_grant),  32'(m_own == 0));
    check_eq("m1_grant",  32'(M1_grant),  32'(m_own == 1));
    check_eq("s_wr",      32'(S_wr),      32'(wr));
    check_eq("s_address", 32'(S_address), 32'(a));
    check_eq("s_dout",    32'(S_dout),    32'(d));
    check_eq("s_sel",     32'(S_sel),     32'(sel));
    check_eq("m_din",     32'(M_din),     32'(din));
    check_eq("bus_err",   32'(bus_err),   32'(m_err));
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic tick();
    #1 check_outputs();
    @(posedge clk);
    if (!reset_n) model_reset();
    else          model_step();
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    M0_req = ($urandom_range(0, 3) != 0);
    M1_req = ($urandom_range(0, 3) != 0);
    M0_wr = 1'($urandom); M1_wr = 1'($urandom);
    M0_address = ADDR_W'($urandom); M1_address = ADDR_W'($urandom);
    M0_dout = $urandom; M1_dout = $urandom;
    S0_din = $urandom; S1_din = $urandom; S2_din = $urandom;
  endtask

  task automatic set_m0(input logic rq, input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    M0_req = rq; M0_wr = w; M0_address = a; M0_dout = d;
  endtask

  task automatic set_m1(input logic rq, input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    M1_req = rq; M1_wr = w; M1_address = a; M1_dout = d;
  endtask

  initial begin
    @(negedge clk);
    // Reset held with random traffic: everything quiet.
    for (int i = 0; i < 4; i++) begin rand_inputs(); tick(); end
    reset_n = 1'b1;
    set_m0(1, 1, 8'h05, 32'h5); set_m1(0, 0, 8'h00, 32'h0);
    S0_din = 32'h11; S1_din = 32'h22; S2_din = 32'h33;
    tick(); tick(); tick();

    // Simultaneous first requests after reset, then M0 drops after two cycles.
    reset_n = 1'b0; model_reset(); tick(); reset_n = 1'b1;
    set_m0(1, 0, 8'h00, 32'h0); set_m1(1, 0, 8'h20, 32'h0);
    tick(); tick(); tick();
    M0_req = 1'b0;
    tick(); tick();

    // Continuous contention, then M1 drops out.
    set_m0(1, 0, 8'h10, 32'hA); set_m1(1, 1, 8'h30, 32'hB);
    for (int i = 0; i < 40; i++) tick();
    M1_req = 1'b0;
    for (int i = 0; i < 20; i++) tick();

    // M1 writes and reads the multiplier region.
    set_m0(0, 0, 8'h00, 32'h0); set_m1(1, 1, 8'h40, 32'd20);
    S2_din = 32'd400;
    tick(); tick();
    M1_address = 8'h42; tick();
    M1_wr = 1'b0; M1_address = 8'h44; tick();

    // M0 accesses to unmapped addresses.
    set_m1(0, 0, 8'h00, 32'h0); set_m0(1, 0, 8'h80, 32'h0);
    tick(); tick(); tick();
    set_m0(1, 1, 8'hE0, 32'hDEAD); tick();
    set_m0(1, 0, 8'h08, 32'h0); tick(); tick();
    set_m0(1, 1, 8'hA0, 32'h1); tick();
    set_m0(0, 0, 8'h00, 32'h0); tick(); tick();

    // Random traffic.
    for (int i = 0; i < 500; i++) begin rand_inputs(); tick(); end

    // Async reset in the middle of an M1 burst.
    set_m0(0, 0, 8'h00, 32'h0); set_m1(1, 1, 8'h44, 32'h7);
    for (int i = 0; i < 4; i++) tick();
    check_eq("pre_rst_m1_grant", 32'(M1_grant), 32'd1);
    #3 reset_n = 1'b0;
    #1;
    check_eq("rst_m1_grant", 32'(M1_grant), 32'd0);
    check_eq("rst_s_wr",     32'(S_wr),     32'd0);
    model_reset();
    @(negedge clk);
    set_m0(1, 0, 8'h00, 32'h0); set_m1(1, 0, 8'h20, 32'h0);
    tick();
    reset_n = 1'b1;
    tick(); tick();
    check_eq("post_rst_m0_first", 32'(M0_grant), 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
